// File: rtl/booth_mul_sched.sv
// Two-requester radix-4 Booth multiplier: round-robin arbitration in IDLE,
// one Booth digit retired per ITER cycle, and the result held in DONE until taken.
module booth_mul_sched #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*N-1:0] res_p,
    output logic           res_id,
    output logic           busy
);

    localparam int HALF  = N / 2;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic                    ptr;
    logic                    grant;
    logic                    accept;
    logic                    id_r;
    logic [CNT_W-1:0]        cnt;
    logic signed [N-1:0]     a_r;
    logic [N-1:0]            b_r;
    logic signed [2*N:0]     acc;

    logic [CNT_W:0]          shamt;
    logic [2:0]              digit;
    logic [N+1:0]            pp_bundle;
    logic signed [2*N:0]     pp_ext;
    logic signed [2*N:0]     neg_ext;
    logic signed [2*N:0]     acc_nxt;
    logic                    acc_msb_unused;

    // Negative digits return the one's complement plus a separate carry bit, so
    // -2a for the most negative a (+2^N) still fits the N+1 bit partial product.
    function automatic logic [N+1:0] booth_pp(input logic [2:0] dig,
                                              input logic signed [N-1:0] a);
        logic signed [N:0] ax;
        logic signed [N:0] pp;
        logic              neg;
        ax  = {a[N-1], a};
        pp  = '0;
        neg = 1'b0;
        case (dig)
            3'b001, 3'b010: pp = ax;
            3'b011:         pp = ax <<< 1;
            3'b100: begin
                pp  = ~(ax <<< 1);
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                pp  = ~ax;
                neg = 1'b1;
            end
            default:        pp = '0;
        endcase
        return {neg, pp};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (req0_valid && (!req1_valid || !ptr)) begin
                        req0_ready = 1'b1;
                        grant      = 1'b0;
                        state_nxt  = ITER;
                    end else if (req1_valid) begin
                        req1_ready = 1'b1;
                        grant      = 1'b1;
                        state_nxt  = ITER;
                    end
                end
            end
            ITER: begin
                if (cnt == LAST_DIGIT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = req0_ready | req1_ready;

    // Digit i is {b[2i+1], b[2i], b[2i-1]} with an implicit zero below bit 0.
    assign shamt     = {cnt, 1'b0};
    assign digit     = 3'({b_r, 1'b0} >> shamt);
    assign pp_bundle = booth_pp(digit, a_r);
    assign pp_ext    = $signed({{N{pp_bundle[N]}}, pp_bundle[N:0]}) <<< shamt;
    assign neg_ext   = {{(2*N){1'b0}}, pp_bundle[N+1]} << shamt;
    assign acc_nxt   = acc + pp_ext + neg_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr  <= 1'b0;
            id_r <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
        end else if (accept) begin
            ptr  <= !grant;
            id_r <= grant;
            cnt  <= '0;
            acc  <= '0;
        end else if (state == ITER) begin
            cnt  <= cnt + CNT_W'(1);
            acc  <= acc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= grant ? req1_a : req0_a;
            b_r <= grant ? req1_b : req0_b;
        end
    end

    // Result bits are the low 2N of the accumulator; the top bit only guards sums.
    assign acc_msb_unused = acc[2*N];
    assign res_valid      = (state == DONE);
    assign res_p          = res_valid ? acc[2*N-1:0] : '0;
    assign res_id         = res_valid & id_r;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_booth_mul_sched.sv
// Bench for booth_mul_sched: directed corner cases plus random traffic checked
// against a plain-multiply, round-robin reference model.
module tb_booth_mul_sched;

    localparam int N    = 8;
    localparam int HALF = N / 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [N-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           res_valid;
    logic           res_ready;
    logic [2*N-1:0] res_p;
    logic           res_id;
    logic           busy;

    int tests = 0;
    int fails = 0;
    int ptr_m = 0;

    booth_mul_sched #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_p      (res_p),
        .res_id     (res_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*N-1:0] mul_ref(input logic [N-1:0] a, input logic [N-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[2*N-1:0];
    endfunction

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst   = 1'b0;
        ptr_m = 0;
    endtask

    // Called and returns at #1 after a rising edge with the DUT in IDLE.
    task automatic txn(input bit v0, input bit v1,
                       input logic [N-1:0] a0, input logic [N-1:0] b0,
                       input logic [N-1:0] a1, input logic [N-1:0] b1,
                       input int stall, input bit keep);
        int who;
        int lat;
        logic [2*N-1:0] exp_p;
        who   = (v0 && v1) ? ptr_m : (v0 ? 0 : 1);
        exp_p = (who == 0) ? mul_ref(a0, b0) : mul_ref(a1, b1);
        req0_valid = v0;
        req1_valid = v1;
        req0_a = a0; req0_b = b0;
        req1_a = a1; req1_b = b1;
        @(negedge clk);
        check("ready0_grant", req0_ready, who == 0);
        check("ready1_grant", req1_ready, who == 1);
        @(posedge clk);
        #1;
        ptr_m = 1 - who;
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            req0_a = N'($urandom); req0_b = N'($urandom);
            req1_a = N'($urandom); req1_b = N'($urandom);
        end
        lat = 0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge clk);
            if (res_valid) begin
                lat = k;
            end else begin
                check("iter_no_ready", {req0_ready, req1_ready}, 0);
                check("iter_res_p_zero", res_p, 0);
            end
        end
        check("latency", lat, HALF + 1);
        if (lat == 0) begin
            do_reset(1);
            return;
        end
        check("res_p", res_p, exp_p);
        check("res_id", res_id, who);
        check("busy_done", busy, 1);
        for (int s = 1; s < stall; s++) begin
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_p", res_p, exp_p);
            check("hold_id", res_id, who);
            check("hold_no_ready", {req0_ready, req1_ready}, 0);
        end
        res_ready = 1'b1;
        #1;
        check("done_no_ready", {req0_ready, req1_ready}, 0);
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("idle_valid", res_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_res_p", res_p, 0);
    endtask

    initial begin
        logic [N-1:0] ca0, cb0, ca1, cb1;
        int v;
        rst        = 1'b1;
        res_ready  = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

        // Reset with both requesters pending
        repeat (2) begin
            @(negedge clk);
            check("rst_ready0", req0_ready, 0);
            check("rst_ready1", req1_ready, 0);
        end
        @(posedge clk);
        #1;
        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        ptr_m      = 0;
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_res_p", res_p, 0);
        check("rst_res_id", res_id, 0);

        // Single request 7 * -3
        txn(1'b1, 1'b0, 8'd7, 8'hFD, 8'h00, 8'h00, 0, 1'b0);

        // Most-negative operand corners
        txn(1'b0, 1'b1, 8'h00, 8'h00, 8'h80, 8'h80, 0, 1'b0);
        txn(1'b0, 1'b1, 8'h00, 8'h00, 8'h80, 8'h7F, 0, 1'b0);

        // Backpressure in DONE
        txn(1'b1, 1'b0, N'($urandom), N'($urandom), 8'h00, 8'h00, 5, 1'b0);

        // Contention after reset: both valids held high for three transactions
        do_reset(1);
        ca0 = N'($urandom); cb0 = N'($urandom);
        ca1 = N'($urandom); cb1 = N'($urandom);
        repeat (3) txn(1'b1, 1'b1, ca0, cb0, ca1, cb1, 0, 1'b1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Abort in the second ITER cycle
        req0_valid = 1'b1;
        req0_a = N'($urandom);
        req0_b = N'($urandom);
        @(negedge clk);
        check("abort_accept", req0_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        rst        = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        check("abort_rst_ready", {req0_ready, req1_ready}, 0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        req1_valid = 1'b0;
        ptr_m      = 0;
        check("abort_busy", busy, 0);
        check("abort_valid", res_valid, 0);
        repeat (6) begin
            @(negedge clk);
            check("abort_no_result", res_valid, 0);
        end
        @(posedge clk);
        #1;
        txn(1'b1, 1'b0, 8'd5, 8'd5, 8'h00, 8'h00, 0, 1'b0);

        // Random traffic
        for (int i = 0; i < 24; i++) begin
            v = $urandom_range(1, 3);
            txn(v[0], v[1], N'($urandom), N'($urandom), N'($urandom), N'($urandom),
                $urandom_range(0, 3), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/booth_mul_sched.md
BOOTH_MUL_SCHED -- requirements
Module: booth_mul_sched

Interface
REQ-001 SHALL have parameter N, default 8, giving the operand width; N SHALL be even and at least 4.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester 0 or 1 presents an operand pair.
REQ-005 SHALL have ports req0_ready and req1_ready, output, 1 bit each: the pair is accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, N bits each: signed two's-complement multiplicand and multiplier.
REQ-007 SHALL have port res_valid, output, 1 bit: a result is held.
REQ-008 SHALL have port res_ready, input, 1 bit: the consumer takes the result.
REQ-009 SHALL have port res_p, output, 2N bits: signed product.
REQ-010 SHALL have port res_id, output, 1 bit: index of the requester that owns res_p.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL implement an FSM with states IDLE, ITER and DONE; state encoding is free.
REQ-013 SHALL assert at most one reqX_ready in any cycle, and only in IDLE; the ready signals are combinational from state, valid inputs and pointer.
REQ-014 SHALL arbitrate in IDLE as follows:
- only one valid: that requester is granted;
- both valid: the requester named by the round-robin pointer ptr is granted;
- ptr resets to 0.
REQ-015 SHALL, on a transfer (valid and ready in the same cycle), do all of the following:
- latch a and b;
- latch the grant index into res_id;
- clear the accumulator and the digit counter;
- set ptr to the non-granted index;
- enter ITER.
REQ-016 SHALL ignore requester inputs while not in IDLE; changes to operands after acceptance SHALL NOT affect the result.
REQ-017 SHALL, in ITER, retire one radix-4 Booth digit per cycle for digits i = 0 .. N/2-1, taken from bits {b[2i+1], b[2i], b[2i-1]} with b[-1] = 0.
REQ-018 SHALL map each digit to a partial product of 0, +a, +2a, -2a or -a, sign-extended and shifted left by 2i before accumulation.
REQ-019 SHALL compute partial products at N+1 bits and accumulate at 2N+1 bits, so that a = -2^(N-1) yields the exact product.
REQ-020 SHALL leave ITER after exactly N/2 cycles and enter DONE with res_p equal to the low 2N bits of the accumulator, which is exactly signed(a) * signed(b).
REQ-021 SHALL assert res_valid from the cycle after the last digit; latency is N/2+1 cycles from the accept edge to res_valid high.
REQ-022 SHALL hold res_valid, res_p and res_id stable in DONE until res_ready is high; on that edge it SHALL enter IDLE.
REQ-023 SHALL NOT accept a new request in the cycle res_valid deasserts; the minimum issue interval is N/2+2 cycles.
REQ-024 SHALL drive res_p, res_id and res_valid to 0 whenever not in DONE.

Reset
REQ-025 SHALL, when rst is high, force state to IDLE and ptr, the accumulator, the counter, res_valid, res_p and res_id to 0; outputs read 0 and busy 0 from the next cycle.
REQ-026 SHALL give rst priority over all other events; reset in ITER or DONE SHALL discard the operation without producing a result.
REQ-027 SHALL hold reqX_ready low during any cycle in which rst is high.

Verification
REQ-028 Reset check (N=8): hold rst high for 2 cycles with both valids high -> ready signals 0; after release res_valid=0, busy=0, res_p=0.
REQ-029 Single request (N=8): req0 a=7, b=-3 -> accepted at T; res_valid at T+5; res_p=16'hFFEB; res_id=0.
REQ-030 Corner operands (N=8): req1 a=-128, b=-128 -> res_p=16'h4000; then a=-128, b=127 -> res_p=16'hC080.
REQ-031 Contention: both valids held high for 3 transactions after reset -> grants in order 0, 1, 0; results carry matching res_id; no overlap.
REQ-032 Backpressure: res_ready held low for 5 cycles in DONE -> res_p, res_id and res_valid stable; both ready signals 0; completion on the first res_ready cycle.
REQ-033 Abort: rst pulsed at the second ITER cycle -> no res_valid; IDLE next cycle; a following request 5 * 5 gives res_p=16'h0019.
